// File: rtl/sram_handshake_bridge_pkg.sv
// Shared definitions for the SRAM-to-handshake bridge:
// FSM state encoding and shared-port size codes.
package sram_handshake_bridge_pkg;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_REQ  = 2'd1,
    BR_WAIT = 2'd2,
    BR_DONE = 2'd3
  } br_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_handshake_bridge_if.sv
// Shared memory port with req/addr_ok/data_ok handshake.
// master = bridge side, slave = memory side.
interface sram_handshake_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_handshake_bridge_size_enc.sv
// Byte-enable to {size, wstrb} encoder for the shared port.
// Reads (we == 0) become full-word accesses with all strobes.
module sram_size_enc
  import sram_handshake_bridge_pkg::*;
(
  input  logic [3:0] we,
  output logic [1:0] size,
  output logic [3:0] wstrb
);

  // classify the enable pattern; odd patterns fall back to word
  always_comb begin
    size  = SIZE_W;
    wstrb = 4'hF;
    unique case (we)
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: size = SIZE_B;
      4'b0011, 4'b1100: size = SIZE_H;
      default:          size = SIZE_W;
    endcase
    if (|we) wstrb = we;
  end

endmodule

// File: rtl/sram_handshake_bridge.sv
// Serialises inst/data SRAM ports onto one req/addr_ok/data_ok port.
// Optional macro SRAM_BRIDGE_PERF_EN adds stall/request counters.
module sram_handshake_bridge
  import sram_handshake_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_we,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_we,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              cpu_stall,
`ifdef SRAM_BRIDGE_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_req_cnt,
`endif
  sram_handshake_bridge_if.master mem
);

  br_state_t         state;
  logic              pend_i;
  logic              pend_d;
  logic [3:0]        i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;

  logic [3:0]        nx_we;
  logic [ADDR_W-1:0] nx_addr;
  logic [DATA_W-1:0] nx_wdata;
  logic [1:0]        nx_size;
  logic [3:0]        nx_wstrb;
  logic              accept;
  logic              done;
  logic              load;

  // next request: data port wins at accept, else the held inst access
  always_comb begin
    nx_we    = i_we;
    nx_addr  = i_addr;
    nx_wdata = i_wdata;
    if (state == BR_IDLE) begin
      if (data_sram_en) begin
        nx_we    = data_sram_we;
        nx_addr  = data_sram_addr;
        nx_wdata = data_sram_wdata;
      end else begin
        nx_we    = inst_sram_we;
        nx_addr  = inst_sram_addr;
        nx_wdata = inst_sram_wdata;
      end
    end
  end

  sram_size_enc u_enc (
    .we    (nx_we),
    .size  (nx_size),
    .wstrb (nx_wstrb)
  );

  // completion may coincide with acceptance in REQ
  always_comb begin
    accept = (state == BR_IDLE) &
             (inst_sram_en | data_sram_en);
    done   = ((state == BR_REQ) & mem.addr_ok & mem.data_ok) |
             ((state == BR_WAIT) & mem.data_ok);
    load   = accept | (done & pend_d & pend_i);
  end

  // stall freezes the core in the accept cycle and until DONE
  always_comb begin
    cpu_stall = 1'b0;
    unique case (state)
      BR_IDLE:          cpu_stall = inst_sram_en | data_sram_en;
      BR_REQ, BR_WAIT:  cpu_stall = 1'b1;
      BR_DONE:          cpu_stall = 1'b0;
    endcase
  end

  // bridge FSM with registered shared-port outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= BR_IDLE;
      pend_i          <= 1'b0;
      pend_d          <= 1'b0;
      i_we            <= '0;
      i_addr          <= '0;
      i_wdata         <= '0;
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
      mem.req         <= 1'b0;
      mem.wr          <= 1'b0;
      mem.size        <= SIZE_B;
      mem.wstrb       <= '0;
      mem.addr        <= '0;
      mem.wdata       <= '0;
    end else begin
      unique case (state)
        BR_IDLE: begin
          if (accept) begin
            pend_i  <= inst_sram_en;
            pend_d  <= data_sram_en;
            i_we    <= inst_sram_we;
            i_addr  <= inst_sram_addr;
            i_wdata <= inst_sram_wdata;
            state   <= BR_REQ;
          end
        end
        BR_REQ: begin
          if (mem.addr_ok) begin
            mem.req <= 1'b0;
            state   <= BR_WAIT;
          end
        end
        BR_WAIT: begin
        end
        BR_DONE: state <= BR_IDLE;
      endcase

      if (done) begin
        if (pend_d) begin
          if (!mem.wr) data_sram_rdata <= mem.rdata;
          pend_d <= 1'b0;
          state  <= pend_i ? BR_REQ : BR_DONE;
        end else begin
          if (!mem.wr) inst_sram_rdata <= mem.rdata;
          pend_i <= 1'b0;
          state  <= BR_DONE;
        end
      end

      if (load) begin
        mem.req   <= 1'b1;
        mem.wr    <= |nx_we;
        mem.size  <= nx_size;
        mem.wstrb <= nx_wstrb;
        mem.addr  <= nx_addr;
        mem.wdata <= nx_wdata;
      end
    end
  end

`ifdef SRAM_BRIDGE_PERF_EN
  // free-running wrap-around performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_req_cnt   <= '0;
    end else begin
      if (cpu_stall)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (mem.req & mem.addr_ok)
        perf_req_cnt <= perf_req_cnt + 32'd1;
    end
  end
`endif

endmodule
